// File: rtl/pe_acc_if.sv
// Handshake bundle between pe_mult, the reduction stage and the PE writeback.
interface pe_acc_if #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
);
  logic             mult_valid;
  logic             mult_ready;
  logic [1023:0]    mult_result;
  logic             mult_last;
  logic             acc_valid;
  logic             acc_ready;
  logic [ACC_W-1:0] acc_result;
  logic [CNT_W-1:0] acc_beats;

  modport master (
    output mult_valid, mult_result, mult_last, acc_ready,
    input  mult_ready, acc_valid, acc_result, acc_beats
  );

  modport slave (
    input  mult_valid, mult_result, mult_last, acc_ready,
    output mult_ready, acc_valid, acc_result, acc_beats
  );
endinterface

// File: rtl/pe_acc.sv
// Two-stage adder tree over 32 int32 lane products, followed by a per-group
// accumulator closed by mult_last. Whole pipe stalls while a result is unread.
module pe_acc #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  pe_acc_if.slave  io_bus
);
  localparam int NUM_LANES = 32;
  localparam int LANE_W    = 32;
  localparam int GRP       = 4;
  localparam int GRP_LANES = NUM_LANES / GRP;
  localparam int P_W       = 35;
  localparam int S_W       = 37;

  logic                      w_en;
  logic                      w_xfer;
  logic [GRP-1:0][P_W-1:0]   w_part;
  logic [S_W-1:0]            w_sum;
  logic [ACC_W-1:0]          w_nxt;
  logic [CNT_W-1:0]          w_cnt_nxt;

  logic [1:0]                r_vld_pipe;
  logic [1:0]                r_last_pipe;
  logic [GRP-1:0][P_W-1:0]   r_s1_part;
  logic [S_W-1:0]            r_s2_sum;
  logic [ACC_W-1:0]          r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_first;
  logic                      r_acc_valid;
  logic [ACC_W-1:0]          r_acc_result;
  logic [CNT_W-1:0]          r_acc_beats;

  assign w_en   = !(r_acc_valid && !io_bus.acc_ready);
  assign w_xfer = io_bus.mult_valid && i_rst_n && w_en;

  assign io_bus.mult_ready = i_rst_n && w_en;
  assign io_bus.acc_valid  = r_acc_valid;
  assign io_bus.acc_result = r_acc_result;
  assign io_bus.acc_beats  = r_acc_beats;

  // 8 lanes of int32 fit in 35 bits, four partials in 37: no tree overflow.
  always_comb begin
    w_part = '0;
    for (int g = 0; g < GRP; g++)
      for (int l = 0; l < GRP_LANES; l++)
        w_part[g] = w_part[g] +
          P_W'($signed(io_bus.mult_result[(g*GRP_LANES+l)*LANE_W +: LANE_W]));
  end

  always_comb begin
    w_sum = '0;
    for (int g = 0; g < GRP; g++)
      w_sum = w_sum + S_W'($signed(r_s1_part[g]));
  end

  always_comb begin
    w_nxt     = (r_first ? '0 : r_acc) + ACC_W'($signed(r_s2_sum));
    w_cnt_nxt = r_first ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_pipe   <= '0;
      r_last_pipe  <= '0;
      r_s1_part    <= '0;
      r_s2_sum     <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_first      <= 1'b1;
      r_acc_valid  <= 1'b0;
      r_acc_result <= '0;
      r_acc_beats  <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[0], w_xfer};
      if (w_xfer) begin
        r_s1_part      <= w_part;
        r_last_pipe[0] <= io_bus.mult_last;
      end
      r_last_pipe[1] <= r_last_pipe[0];
      r_s2_sum       <= w_sum;
      // en high with a pending result implies acc_ready: it is consumed now.
      r_acc_valid    <= 1'b0;
      if (r_vld_pipe[1]) begin
        if (r_last_pipe[1]) begin
          r_acc_result <= w_nxt;
          r_acc_beats  <= w_cnt_nxt;
          r_acc_valid  <= 1'b1;
          r_first      <= 1'b1;
        end else begin
          r_acc   <= w_nxt;
          r_cnt   <= w_cnt_nxt;
          r_first <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_acc.sv
// Random and directed stimulus for pe_acc against a group-sum reference model.
module tb_pe_acc;
  localparam int ACC_W = 48;
  localparam int CNT_W = 4;
  localparam longint MAXC = (64'd1 << CNT_W) - 1;

  typedef struct {
    logic [ACC_W-1:0] res;
    logic [CNT_W-1:0] n;
  } exp_t;

  typedef struct {
    logic [63:0] res;
    logic [63:0] n;
    int          cyc;
  } got_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     n_chk = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     xfer_cyc;
  int     base;
  exp_t   expq[$];
  got_t   got[$];
  longint grp_sum = 0;
  longint grp_n = 0;
  logic   prev_stall = 1'b0;
  logic [63:0] prev_res, prev_beats;

  pe_acc_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  pe_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m(input longint v);
    logic [63:0] t;
    t = v;
    return t & ((64'd1 << ACC_W) - 1);
  endfunction

  function automatic logic [1023:0] fill(input logic [31:0] v);
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = v;
    return r;
  endfunction

  // Reference model: group sum of all accepted lane values, plus handshake rules.
  always @(negedge clk) begin
    exp_t   e;
    longint s;
    if (!rst_n) begin
      chk("ready_in_reset", {63'b0, bus.mult_ready}, 64'd0);
      grp_sum = 0; grp_n = 0; expq.delete(); prev_stall = 1'b0;
    end else begin
      chk("ready_rule", {63'b0, bus.mult_ready},
          {63'b0, !(bus.acc_valid && !bus.acc_ready)});
      if (prev_stall) begin
        chk("stall_valid", {63'b0, bus.acc_valid}, 64'd1);
        chk("stall_res", 64'(bus.acc_result), prev_res);
        chk("stall_beats", 64'(bus.acc_beats), prev_beats);
      end
      prev_stall = bus.acc_valid && !bus.acc_ready;
      prev_res   = 64'(bus.acc_result);
      prev_beats = 64'(bus.acc_beats);
      if (bus.acc_valid && bus.acc_ready) begin
        if (expq.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
        else begin
          e = expq.pop_front();
          chk("result", 64'(bus.acc_result), 64'(e.res));
          chk("beats", 64'(bus.acc_beats), 64'(e.n));
        end
        got.push_back('{64'(bus.acc_result), 64'(bus.acc_beats), cyc});
      end
      if (bus.mult_valid && bus.mult_ready) begin
        s = 0;
        for (int i = 0; i < 32; i++) s += longint'($signed(bus.mult_result[32*i +: 32]));
        grp_sum += s;
        grp_n++;
        if (bus.mult_last) begin
          e.res = grp_sum[ACC_W-1:0];
          e.n   = (grp_n > MAXC) ? CNT_W'(MAXC) : CNT_W'(grp_n);
          expq.push_back(e);
          grp_sum = 0; grp_n = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1023:0] d, input logic last);
    int t = 0;
    bus.mult_valid  = 1'b1;
    bus.mult_result = d;
    bus.mult_last   = last;
    @(negedge clk);
    while (!bus.mult_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("beat_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    xfer_cyc = cyc;
    bus.mult_valid = 1'b0;
    bus.mult_last  = 1'b0;
  endtask

  task automatic wait_n(input int n);
    int t = 0;
    while (got.size() < n && t < 200) begin @(posedge clk); t++; end
    #1;
    if (got.size() < n) chk("wait_timeout", 64'(got.size()), 64'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.mult_valid = 1'b0; bus.mult_result = '0; bus.mult_last = 1'b0; bus.acc_ready = 1'b1;
    idle(3);
    chk("rst_acc_valid", {63'b0, bus.acc_valid}, 64'd0);
    chk("rst_acc_result", 64'(bus.acc_result), 64'd0);
    chk("rst_acc_beats", 64'(bus.acc_beats), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {63'b0, bus.mult_ready}, 64'd1);
    @(posedge clk); #1;

    // single beat, latency
    beat(fill(32'd1), 1'b1);
    wait_n(1);
    chk("single_res", got[0].res, 64'd32);
    chk("single_beats", got[0].n, 64'd1);
    chk("latency", 64'(got[0].cyc - xfer_cyc), 64'd2);

    // back-to-back groups
    for (int i = 0; i < 4; i++) beat(fill(32'hFFFF_FFFF), i == 3);
    beat(fill(32'd2), 1'b1);
    wait_n(3);
    chk("neg_res", got[1].res, m(-128));
    chk("neg_beats", got[1].n, 64'd4);
    chk("next_res", got[2].res, 64'd64);
    chk("next_gap", 64'(got[2].cyc - got[1].cyc), 64'd1);

    // extremes
    beat(fill(32'h4000_0000), 1'b1);
    beat(fill(32'h8000_0000), 1'b0);
    beat(fill(32'h8000_0000), 1'b1);
    wait_n(5);
    chk("max_pos", got[3].res, 64'd1 << 35);
    chk("max_neg", got[4].res, m(-(longint'(1) << 37)));
    chk("max_neg_beats", got[4].n, 64'd2);

    // backpressure
    base = got.size();
    bus.acc_ready = 1'b0;
    beat(fill(32'd3), 1'b1);
    beat(fill(32'd1), 1'b1);
    beat(fill(32'd7), 1'b1);
    @(negedge clk);
    chk("bp_valid", {63'b0, bus.acc_valid}, 64'd1);
    chk("bp_ready_drop", {63'b0, bus.mult_ready}, 64'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_frozen", 64'(bus.acc_result), 64'd96);
    end
    @(posedge clk); #1;
    chk("bp_none_out", 64'(got.size()), 64'(base));
    bus.acc_ready = 1'b1;
    wait_n(base + 3);
    idle(5);
    chk("bp_count", 64'(got.size()), 64'(base + 3));
    chk("bp_order0", got[base].res, 64'd96);
    chk("bp_order1", got[base+1].res, 64'd32);
    chk("bp_order2", got[base+2].res, 64'd224);

    // gaps inside a group
    base = got.size();
    beat(fill(32'd1), 1'b0); idle(2);
    beat(fill(32'd2), 1'b0); idle(2);
    beat(fill(32'd3), 1'b1);
    wait_n(base + 1);
    chk("gap_res", got[base].res, 64'd192);
    chk("gap_beats", got[base].n, 64'd3);

    // beat counter saturation
    base = got.size();
    for (int i = 0; i < 20; i++) beat(fill(32'd1), i == 19);
    wait_n(base + 1);
    chk("sat_res", got[base].res, 64'd640);
    chk("sat_beats", got[base].n, MAXC);

    // reset mid-group
    base = got.size();
    beat(fill(32'd5), 1'b0);
    beat(fill(32'd5), 1'b0);
    idle(1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {63'b0, bus.acc_valid}, 64'd0);
    chk("mid_rst_result", 64'(bus.acc_result), 64'd0);
    chk("mid_rst_ready", {63'b0, bus.mult_ready}, 64'd1);
    @(posedge clk); #1;
    beat(fill(32'd1), 1'b1);
    wait_n(base + 1);
    chk("rst_grp_res", got[base].res, 64'd32);
    chk("rst_grp_beats", got[base].n, 64'd1);

    // randomized traffic
    base = got.size();
    for (int c = 0; c < 600; c++) begin
      bus.mult_valid = ($urandom_range(0, 3) != 0);
      bus.mult_last  = ($urandom_range(0, 3) == 0);
      bus.acc_ready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 32; i++) bus.mult_result[32*i +: 32] = $urandom;
      @(posedge clk); #1;
    end
    bus.mult_valid = 1'b0;
    bus.mult_last  = 1'b1;
    bus.acc_ready  = 1'b1;
    idle(10);
    chk("drain_empty", 64'(expq.size()), 64'd0);
    chk("rand_some_results", {63'b0, got.size() > base + 20}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pe_acc.md
# pe_acc

Downstream reduction stage for `pe_mult`. It takes the 1024-bit bus of 32 signed int32 lane products and sums them through a two-stage pipelined adder tree. Consecutive beats are then accumulated into one signed result per dot-product group, with the group closed by `mult_last`. The block sits between `pe_mult` and the PE output/writeback logic, with valid/ready handshakes on both sides.

## Interface
- `ACC_W`, default 48: accumulator and output width in bits; must be at least 37.
- `CNT_W`, default 16: width of the beat counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mult_valid`  in  1  an input beat is present.
- `mult_ready`  out  1  block accepts a beat; a beat transfers when `mult_valid && mult_ready` at a rising edge.
- `mult_result`  in  1024  32 signed int32 products; lane i is bits [32i+31:32i].
- `mult_last`  in  1  this beat closes the current group.
- `acc_valid`  out  1  `acc_result` holds a completed group sum.
- `acc_ready`  in  1  consumer takes the result.
- `acc_result`  out  ACC_W  signed group sum.
- `acc_beats`  out  CNT_W  number of beats in the completed group, saturating at all-ones.

## Operation
- Stall signal: `en = !(acc_valid && !acc_ready)`.
  - `mult_ready = rst_n && en` (combinational).
  - When `en` is 0, every pipeline register holds, including all valid, last, and accumulator state.
- Stage S1, loaded on a transfer:
  - Four partial sums, each the sum of 8 lanes (lanes 0-7, 8-15, 16-23, 24-31).
  - Each partial sum is 35 bits, sign-extended.
  - `s1_valid` and `s1_last` are captured with the data.
  - When `en` is 1 and there is no transfer, `s1_valid` becomes 0 (bubble).
- Stage S2: when `en` is 1, loads the 37-bit signed sum of the four S1 partials, plus `s2_valid` and `s2_last`.
- Accumulator stage, when `en` is 1 and `s2_valid` is 1:
  - `nxt = (first ? 0 : acc) + sext(s2_sum)`, computed modulo 2^ACC_W with no saturation.
  - `first` is 1 after reset and after each completed group.
  - `cnt_nxt = first ? 1 : sat(cnt + 1)`.
  - If `s2_last` is 0: `acc <= nxt`, `cnt <= cnt_nxt`, `first <= 0`.
  - If `s2_last` is 1: `acc_result <= nxt`, `acc_beats <= cnt_nxt`, `acc_valid <= 1`, `first <= 1`.
- Output handshake:
  - `acc_valid` clears on an edge with `acc_ready` high, unless a new result is loaded on the same edge; then it stays 1 with the new data.
  - `acc_result` and `acc_beats` are held stable while `acc_valid && !acc_ready`.
- A one-beat group (`mult_last` on the first beat) yields the tree sum of that beat with `acc_beats` = 1.
- `mult_valid` low between beats of a group is allowed; the bubbles do not alter `acc`.
- Reset (`rst_n` low at an edge), including mid-group or mid-stall:
  - Loads `s1_valid`, `s2_valid`, `acc_valid` = 0, `acc` = 0, `acc_result` = 0, `acc_beats` = 0, `cnt` = 0, `first` = 1.
  - Any partial group and any in-flight beats are discarded.
  - `mult_ready` is 0 while `rst_n` is low.

## Timing
- Latency: a last beat transferred at the end of cycle 0 gives `acc_valid` = 1 in cycle 3 with no backpressure.
- Throughput: one beat per cycle while `acc_ready` stays high or `acc_valid` is 0.
- A new group may start on the beat immediately after a `mult_last` beat; there are no idle cycles between groups.
- Backpressure path: `acc_ready` to `mult_ready` is combinational (one AND plus inverter). There is no skid buffer.
- After reset release, `mult_ready` = 1 in the first cycle with `rst_n` high.
- Critical path: 8-input adder in S1 and 4-input adder in S2; the accumulator add is ACC_W bits.

## Test plan
- Single beat, all lanes 1, `mult_last` = 1 in cycle 0, `acc_ready` = 1 → `acc_valid` in cycle 3, `acc_result` = 32, `acc_beats` = 1.
- Four beats back-to-back, all lanes 0xFFFFFFFF (-1), last on beat 4 → `acc_result` = -128 (sign-extended over ACC_W), `acc_beats` = 4; then a one-beat group of all lanes 2 the next cycle → second result 64 exactly one cycle after the first.
- Extreme values: all lanes 0x40000000 for 1 beat → 2^35. All lanes 0x80000000 for 2 beats → -2^37. No tree overflow in either case.
- Backpressure:
  - Hold `acc_ready` = 0 when a result appears → `mult_ready` drops the same cycle, and `acc_result` and pipeline contents are frozen for 5 cycles.
  - Release `acc_ready` → results come out in order, none lost or duplicated.
- Gaps: a 3-beat group with `mult_valid` low for 2 cycles between beats (lane values 1, 2, 3) → `acc_result` = 192, `acc_beats` = 3.
- Reset mid-group: 2 beats of value 5 accepted, assert `rst_n` low for 1 cycle, then a one-beat group of value 1 → `acc_result` = 32, `acc_beats` = 1. `acc_valid` is 0 from the reset edge until that result.
